// File: rtl/lock_pkg.sv
// Shared types and constants for the lock/unlock arbiter.
package lock_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        RESP    = 2'd2,
        LOCKOUT = 2'd3
    } state_e;

    // Default key that unlocks any bit
    localparam logic [31:0] DEF_UNLOCK_KEY = 32'hA5C3_0F96;

    // Width of the consecutive-failure counter
    localparam int unsigned FAIL_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the rotating pointer.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int unsigned      cand;

    // Search from the pointer for the first pending request and advance past a grant
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr_q) + i) % N;
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
        gnt   = (en && found) ? (N'(1) << gnt_idx) : '0;
        ptr_d = ptr_q;
        if (en && found) begin
            ptr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    // Rotating priority pointer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lock_unlock_arbiter.sv
// Lock-bit controller: arbitrated unlock/relock requests with key check and timed lockout.
module lock_unlock_arbiter
    import lock_pkg::*;
#(
    parameter int unsigned     NUM_REQ     = 4,
    parameter int unsigned     KEY_W       = 32,
    parameter logic [KEY_W-1:0] UNLOCK_KEY = KEY_W'(DEF_UNLOCK_KEY),
    parameter int unsigned     MAX_FAIL    = 3,
    parameter int unsigned     LOCKOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_relock,
    input  logic [NUM_REQ*KEY_W-1:0]   req_key,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       resp_valid,
    output logic                       resp_ok,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [NUM_REQ-1:0]         locked,
    output logic                       lockout,
    output logic [FAIL_W-1:0]          fail_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(LOCKOUT_CYC);

    state_e             state_q,      state_d;
    logic [IDX_W-1:0]   id_q,         id_d;
    logic               relock_q,     relock_d;
    logic [KEY_W-1:0]   key_q,        key_d;
    logic [NUM_REQ-1:0] locked_q,     locked_d;
    logic [FAIL_W-1:0]  fail_q,       fail_d;
    logic               lockout_q,    lockout_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_ok_q,    resp_ok_d;
    logic [IDX_W-1:0]   resp_id_q,    resp_id_d;

    logic               arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               key_match;

    assign arb_en    = (state_q == IDLE);
    assign key_match = (key_q == UNLOCK_KEY);

    // Grants only while idle, so the grant pulse is exactly one cycle per operation
    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req_valid),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Next-state and next-output logic for the controller
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        relock_d     = relock_q;
        key_d        = key_q;
        locked_d     = locked_q;
        fail_d       = fail_q;
        lockout_d    = lockout_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_ok_d    = 1'b0;
        resp_id_d    = resp_id_q;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    id_d     = gnt_idx;
                    relock_d = req_relock[gnt_idx];
                    key_d    = req_key[gnt_idx*KEY_W +: KEY_W];
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                // Result becomes visible in the RESP cycle
                resp_valid_d = 1'b1;
                resp_id_d    = id_q;
                if (relock_q) begin
                    locked_d[id_q] = 1'b1;
                    resp_ok_d      = 1'b1;
                end else if (key_match) begin
                    locked_d[id_q] = 1'b0;
                    resp_ok_d      = 1'b1;
                    fail_d         = '0;
                end else if (fail_q < FAIL_W'(MAX_FAIL)) begin
                    fail_d = fail_q + FAIL_W'(1);
                end
                state_d = RESP;
            end
            RESP: begin
                // Key material is not retained past the check
                key_d = '0;
                if (fail_q == FAIL_W'(MAX_FAIL)) begin
                    state_d   = LOCKOUT;
                    lockout_d = 1'b1;
                    locked_d  = '1;
                    cnt_d     = CNT_W'(LOCKOUT_CYC - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (cnt_q == '0) begin
                    lockout_d = 1'b0;
                    fail_d    = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            id_q         <= '0;
            relock_q     <= 1'b0;
            key_q        <= '0;
            locked_q     <= '1;
            fail_q       <= '0;
            lockout_q    <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            relock_q     <= relock_d;
            key_q        <= key_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            lockout_q    <= lockout_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
            resp_id_q    <= resp_id_d;
        end
    end

    assign req_ready  = gnt;
    assign resp_valid = resp_valid_q;
    assign resp_ok    = resp_ok_q;
    assign resp_id    = resp_id_q;
    assign locked     = locked_q;
    assign lockout    = lockout_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_lock_unlock_arbiter.sv
// Bench for lock_unlock_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_lock_unlock_arbiter;

    localparam int N    = 4;
    localparam int KW   = 32;
    localparam int MAXF = 3;
    localparam int LCYC = 1024;
    localparam logic [31:0] UKEY = 32'hA5C3_0F96;

    logic           clk;
    logic           resetn;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_relock;
    logic [N*KW-1:0] req_key;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic           resp_ok;
    logic [1:0]     resp_id;
    logic [N-1:0]   locked;
    logic           lockout;
    logic [3:0]     fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    lock_unlock_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_relock (req_relock),
        .req_key    (req_key),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ok    (resp_ok),
        .resp_id    (resp_id),
        .locked     (locked),
        .lockout    (lockout),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    longint       t = 0;
    longint       next_grant_t = 0;
    longint       resp_due = -1;
    longint       lo_start = -1;
    longint       lo_end = -1;
    int           m_ptr = 0;
    int           m_id = 0;
    bit           m_rel = 0;
    logic [31:0]  m_key = '0;
    logic [N-1:0] m_locked = '1;
    int           m_fail = 0;
    bit           m_lo = 0;
    bit           m_rv = 0;
    bit           m_ok = 0;
    int           m_rid = 0;

    // Per-cycle prediction and comparison, sampled mid-cycle
    always @(negedge clk) begin : mon
        int w;
        logic [N-1:0] exp_rdy;
        if (!resetn) begin
            next_grant_t = 0; resp_due = -1; lo_start = -1; lo_end = -1;
            m_ptr = 0; m_locked = '1; m_fail = 0; m_lo = 0; m_rv = 0; m_ok = 0; m_rid = 0;
            check("rst_ready",  64'(req_ready),  64'(0));
            check("rst_rvalid", 64'(resp_valid), 64'(0));
            check("rst_rok",    64'(resp_ok),    64'(0));
            check("rst_rid",    64'(resp_id),    64'(0));
            check("rst_locked", 64'(locked),     64'(4'hF));
            check("rst_lockout",64'(lockout),    64'(0));
            check("rst_fail",   64'(fail_cnt),   64'(0));
        end else begin
            if (resp_due == t) begin
                m_rv = 1; m_rid = m_id;
                if (m_rel) begin
                    m_locked[m_id] = 1'b1; m_ok = 1;
                end else if (m_key == UKEY) begin
                    m_locked[m_id] = 1'b0; m_ok = 1; m_fail = 0;
                end else begin
                    m_ok = 0;
                    if (m_fail < MAXF) m_fail++;
                    if (m_fail == MAXF) begin
                        lo_start = t + 1; lo_end = t + 1 + LCYC; next_grant_t = lo_end;
                    end
                end
            end else begin
                m_rv = 0; m_ok = 0;
            end
            if (lo_end == t)   begin m_lo = 0; m_fail = 0; end
            if (lo_start == t) begin m_lo = 1; m_locked = '1; end

            exp_rdy = '0; w = -1;
            if (t >= next_grant_t) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                if (w >= 0) exp_rdy[w] = 1'b1;
            end

            check("req_ready", 64'(req_ready),  64'(exp_rdy));
            check("resp_valid",64'(resp_valid), 64'(m_rv));
            if (m_rv) begin
                check("resp_ok", 64'(resp_ok), 64'(m_ok));
                check("resp_id", 64'(resp_id), 64'(m_rid));
            end
            check("locked",    64'(locked),   64'(m_locked));
            check("lockout",   64'(lockout),  64'(m_lo));
            check("fail_cnt",  64'(fail_cnt), 64'(m_fail));

            if (w >= 0) begin
                resp_due = t + 2; next_grant_t = t + 3;
                m_id = w; m_rel = req_relock[w]; m_key = req_key[w*KW +: KW];
                m_ptr = (w + 1) % N;
            end
        end
        t++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input bit rel, input logic [31:0] key);
        req_valid[i]          = 1'b1;
        req_relock[i]         = rel;
        req_key[i*KW +: KW]   = key;
    endtask

    // Run until every pending request is granted, then let the last response land
    task automatic drain(input int bound);
        int n;
        logic [N-1:0] got;
        n = 0;
        while (req_valid != '0 && n < bound) begin
            @(negedge clk); got = req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~got;
            n++;
        end
        check("drain_timeout", 64'(req_valid), 64'(0));
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic new_op(input int i);
        int r;
        r = $urandom_range(3);
        req_relock[i] = ($urandom_range(3) == 0);
        req_key[i*KW +: KW] = (r < 2) ? UKEY : ((r == 2) ? 32'h0 : 32'($urandom));
        req_valid[i] = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0] got;
        resetn = 1'b0; req_valid = '0; req_relock = '0; req_key = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single unlock of requester 2
        set_req(2, 1'b0, UKEY);
        drain(10);
        @(negedge clk); check("unlock2_locked", 64'(locked), 64'(4'b1011));
        @(posedge clk); #1;

        // Three simultaneous unlocks, then a relock of requester 1
        set_req(0, 1'b0, UKEY); set_req(1, 1'b0, UKEY); set_req(3, 1'b0, UKEY);
        drain(30);
        @(negedge clk); check("multi_locked", 64'(locked), 64'(4'b0000));
        @(posedge clk); #1;
        set_req(1, 1'b1, 32'h0);
        drain(10);
        @(negedge clk); check("relock1_locked", 64'(locked), 64'(4'b0010));
        @(posedge clk); #1;

        // Three wrong keys trigger lockout; requester 0 waits it out
        for (int k = 0; k < 3; k++) begin
            set_req(1, 1'b0, 32'h0);
            drain(10);
            @(negedge clk); check("wrong_fail", 64'(fail_cnt), 64'(k + 1));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("lo_active", 64'(lockout), 64'(1));
        check("lo_locked", 64'(locked),  64'(4'hF));
        @(posedge clk); #1;
        set_req(0, 1'b0, UKEY);
        drain(LCYC + 20);
        @(negedge clk);
        check("post_lo_locked", 64'(locked), 64'(4'b1110));
        check("post_lo_fail",   64'(fail_cnt), 64'(0));
        @(posedge clk); #1;

        // Two wrong keys then a correct one clears the count
        for (int k = 0; k < 2; k++) begin
            set_req(3, 1'b0, 32'hDEAD_BEEF);
            drain(10);
        end
        @(negedge clk); check("two_wrong_fail", 64'(fail_cnt), 64'(2));
        @(posedge clk); #1;
        set_req(3, 1'b0, UKEY);
        drain(10);
        @(negedge clk);
        check("recover_fail",   64'(fail_cnt), 64'(0));
        check("recover_locked", 64'(locked),   64'(4'b0110));
        check("recover_lo",     64'(lockout),  64'(0));
        @(posedge clk); #1;

        // Reset while the controller is checking a key
        set_req(2, 1'b0, UKEY);
        @(negedge clk); check("rst_case_grant", 64'(req_ready), 64'(4'b0100));
        @(posedge clk); #1;
        resetn = 1'b0; req_valid = '0;
        @(negedge clk); check("rst_case_locked", 64'(locked), 64'(4'hF));
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        set_req(1, 1'b0, UKEY);
        drain(10);
        @(negedge clk); check("after_rst_locked", 64'(locked), 64'(4'b1101));
        @(posedge clk); #1;

        // Random traffic
        repeat (5000) begin
            @(negedge clk); got = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (got[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(31) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    new_op(i);
                end
            end
        end
        req_valid = '0;
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
